// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong constants: FSM state codes, winner codes, score width.
package pong_pkg;

  localparam int SCORE_W = 4;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SERVE_WAIT = 3'd1;
  localparam logic [2:0] ST_PLAY       = 3'd2;
  localparam logic [2:0] ST_OVER       = 3'd3;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  typedef logic [SCORE_W-1:0] score_t;

  // Verdict when the match ends on the clock rather than on reaching the winning score.
  function automatic logic [1:0] compare_scores(input score_t a, input score_t b);
    if (a > b) begin
      return WIN_P1;
    end else if (b > a) begin
      return WIN_P2;
    end
    return WIN_DRAW;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - rising-edge detector; the flop resets to 1 so a level held across reset is not a rise.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level_q <= 1'b1;
    end else begin
      r_level_q <= i_level;
    end
  end

  assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/match_referee.sv
// rtl/match_referee.sv - Pong match referee: scoring, serve delay sequencing, winner decision, OVER blink.
module match_referee
  import pong_pkg::*;
#(
  parameter int SERVE_DELAY = 100_000_000,
  parameter int WIN_SCORE   = 7,
  parameter int BLINK_HALF  = 12_500_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               miss1,
  input  logic               miss2,
  input  logic               time_up,
  output logic               stop,
  output logic               serve,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic               blink,
  output logic [2:0]         state
);

  localparam int DLY_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(SERVE_DELAY - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);
  localparam score_t WIN_S = score_t'(WIN_SCORE);

  logic [2:0]       r_state;
  logic             r_serve;
  score_t           r_score1;
  score_t           r_score2;
  logic [1:0]       r_winner;
  logic             r_blink;
  logic [DLY_W-1:0] r_delay;
  logic [BLK_W-1:0] r_blink_cnt;

  logic   w_start_rise;
  logic   w_rise1;
  logic   w_rise2;
  logic   w_any_rise;
  score_t w_score1_nx;
  score_t w_score2_nx;
  logic   w_play_to_over;
  logic [1:0] w_play_winner;

  rise_detect u_rise_start (
    .clk     (clk),
    .rst     (rst),
    .i_level (start),
    .o_rise  (w_start_rise)
  );

  rise_detect u_rise_miss1 (
    .clk     (clk),
    .rst     (rst),
    .i_level (miss1),
    .o_rise  (w_rise1)
  );

  rise_detect u_rise_miss2 (
    .clk     (clk),
    .rst     (rst),
    .i_level (miss2),
    .o_rise  (w_rise2)
  );

  assign w_any_rise = w_rise1 | w_rise2;

  // A simultaneous miss by both players is a replayed point: neither score moves.
  always_comb begin
    w_score1_nx = r_score1;
    w_score2_nx = r_score2;
    if (w_rise2 && !w_rise1) begin
      w_score1_nx = r_score1 + score_t'(1);
    end
    if (w_rise1 && !w_rise2) begin
      w_score2_nx = r_score2 + score_t'(1);
    end
  end

  always_comb begin
    w_play_to_over = 1'b0;
    w_play_winner  = WIN_NONE;
    if (w_any_rise && (w_score1_nx == WIN_S)) begin
      w_play_to_over = 1'b1;
      w_play_winner  = WIN_P1;
    end else if (w_any_rise && (w_score2_nx == WIN_S)) begin
      w_play_to_over = 1'b1;
      w_play_winner  = WIN_P2;
    end else if (time_up) begin
      w_play_to_over = 1'b1;
      w_play_winner  = compare_scores(w_score1_nx, w_score2_nx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_serve     <= 1'b0;
      r_score1    <= '0;
      r_score2    <= '0;
      r_winner    <= WIN_NONE;
      r_blink     <= 1'b0;
      r_delay     <= '0;
      r_blink_cnt <= '0;
    end else begin
      r_serve <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_score1 <= '0;
          r_score2 <= '0;
          r_winner <= WIN_NONE;
          r_blink  <= 1'b0;
          if (w_start_rise) begin
            r_state <= ST_SERVE_WAIT;
            r_delay <= DLY_LOAD;
          end
        end

        ST_SERVE_WAIT: begin
          if (time_up) begin
            r_state     <= ST_OVER;
            r_winner    <= compare_scores(r_score1, r_score2);
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
          end else if (r_delay == '0) begin
            r_state <= ST_PLAY;
            r_serve <= 1'b1;
          end else begin
            r_delay <= r_delay - 1'b1;
          end
        end

        ST_PLAY: begin
          r_score1 <= w_score1_nx;
          r_score2 <= w_score2_nx;
          if (w_play_to_over) begin
            r_state     <= ST_OVER;
            r_winner    <= w_play_winner;
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
          end else if (w_any_rise) begin
            r_state <= ST_SERVE_WAIT;
            r_delay <= DLY_LOAD;
          end
        end

        ST_OVER: begin
          if (w_start_rise) begin
            r_state     <= ST_IDLE;
            r_score1    <= '0;
            r_score2    <= '0;
            r_winner    <= WIN_NONE;
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
          end else if (r_blink_cnt == BLK_LAST) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
          end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_score1 <= '0;
          r_score2 <= '0;
          r_winner <= WIN_NONE;
          r_blink  <= 1'b0;
        end
      endcase
    end
  end

  assign stop   = (r_state != ST_PLAY);
  assign serve  = r_serve;
  assign score1 = r_score1;
  assign score2 = r_score2;
  assign winner = r_winner;
  assign blink  = r_blink;
  assign state  = r_state;

endmodule

// File: tb/tb_match_referee.sv
// tb/tb_match_referee.sv - scoreboard bench for match_referee: directed scenarios then random play.
module tb_match_referee;

  localparam int SD = 4;
  localparam int WS = 3;
  localparam int BH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       miss1 = 1'b0;
  logic       miss2 = 1'b0;
  logic       time_up = 1'b0;
  logic       stop;
  logic       serve;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] winner;
  logic       blink;
  logic [2:0] state;

  match_referee #(
    .SERVE_DELAY (SD),
    .WIN_SCORE   (WS),
    .BLINK_HALF  (BH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .miss1   (miss1),
    .miss2   (miss2),
    .time_up (time_up),
    .stop    (stop),
    .serve   (serve),
    .score1  (score1),
    .score2  (score2),
    .winner  (winner),
    .blink   (blink),
    .state   (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int stp;
    int srv;
    int s1;
    int s2;
    int w;
    int bl;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Reference game: phases 0 idle, 1 waiting to serve, 2 rally, 3 finished.
  int m_n = 0;
  int m_ph = 0;
  int m_s1 = 0;
  int m_s2 = 0;
  int m_w = 0;
  int m_serve_due = 0;
  int m_over_at = 0;
  bit m_p_st = 1'b1;
  bit m_p_m1 = 1'b1;
  bit m_p_m2 = 1'b1;

  function automatic int judge(input int a, input int b);
    if (a > b) return 1;
    if (b > a) return 2;
    return 3;
  endfunction

  task automatic finish_match(input int who);
    m_ph = 3;
    m_w = who;
    m_over_at = m_n;
  endtask

  task automatic model_edge(input bit a_rst, input bit a_st, input bit a_m1, input bit a_m2, input bit a_tu);
    exp_t e;
    bit rs, r1, r2;
    int srv;
    srv = 0;
    m_n++;
    if (a_rst) begin
      m_ph = 0; m_s1 = 0; m_s2 = 0; m_w = 0;
      m_p_st = 1'b1; m_p_m1 = 1'b1; m_p_m2 = 1'b1;
    end else begin
      rs = a_st && !m_p_st;
      r1 = a_m1 && !m_p_m1;
      r2 = a_m2 && !m_p_m2;
      case (m_ph)
        0: if (rs) begin
          m_ph = 1;
          m_serve_due = m_n + SD;
        end
        1: if (a_tu) finish_match(judge(m_s1, m_s2));
           else if (m_n == m_serve_due) begin
             m_ph = 2;
             srv = 1;
           end
        2: begin
          if (r2 && !r1) m_s1 = m_s1 + 1;
          if (r1 && !r2) m_s2 = m_s2 + 1;
          if ((r1 || r2) && m_s1 == WS) finish_match(1);
          else if ((r1 || r2) && m_s2 == WS) finish_match(2);
          else if (a_tu) finish_match(judge(m_s1, m_s2));
          else if (r1 || r2) begin
            m_ph = 1;
            m_serve_due = m_n + SD;
          end
        end
        default: if (rs) begin
          m_ph = 0; m_s1 = 0; m_s2 = 0; m_w = 0;
        end
      endcase
      m_p_st = a_st; m_p_m1 = a_m1; m_p_m2 = a_m2;
    end
    e.ph  = m_ph;
    e.stp = (m_ph != 2) ? 1 : 0;
    e.srv = srv;
    e.s1  = m_s1;
    e.s2  = m_s2;
    e.w   = m_w;
    e.bl  = (m_ph == 3) ? (((m_n - m_over_at) / BH) % 2) : 0;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit a_rst, input bit a_st, input bit a_m1, input bit a_m2, input bit a_tu);
    @(posedge clk);
    #3;
    rst = a_rst; start = a_st; miss1 = a_m1; miss2 = a_m2; time_up = a_tu;
    model_edge(a_rst, a_st, a_m1, a_m2, a_tu);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic point(input bit a_m1, input bit a_m2);
    step(1'b0, 1'b0, a_m1, a_m2, 1'b0);
    idle_cycles(SD + 3);
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      if (bad <= 40) $display("FAIL %s at cycle %0d: got=%0d exp=%0d", name, total / 7, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", int'(state), e.ph);
        chk("stop", int'(stop), e.stp);
        chk("serve", int'(serve), e.srv);
        chk("score1", int'(score1), e.s1);
        chk("score2", int'(score2), e.s2);
        chk("winner", int'(winner), e.w);
        chk("blink", int'(blink), e.bl);
      end
    end
  end

  initial begin
    bit r_st, r_m1, r_m2, r_tu, r_rs;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);
    // start, serve, then a held miss1 scores exactly once
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(SD + 2);
    repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cycles(SD + 2);
    point(1'b0, 1'b1);
    point(1'b1, 1'b1);
    point(1'b0, 1'b1);
    point(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycles(3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);
    // fresh match won by player 1, blink observed in OVER
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(SD + 2);
    point(1'b0, 1'b1);
    point(1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles(9);
    // reset during SERVE_WAIT with start held
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(SD + 3);
    // random play
    r_st = 1'b0; r_m1 = 1'b0; r_m2 = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) r_st = ~r_st;
      if ($urandom_range(0, 5) == 0) r_m1 = ~r_m1;
      if ($urandom_range(0, 5) == 0) r_m2 = ~r_m2;
      if ($urandom_range(0, 29) == 0) begin
        r_m1 = 1'b1;
        r_m2 = 1'b1;
      end
      r_tu = ($urandom_range(0, 149) == 0);
      r_rs = ($urandom_range(0, 799) == 0);
      step(r_rs, r_st, r_m1, r_m2, r_tu);
    end
    idle_cycles(2);
    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
